// File: rtl/lsu_pkg.sv
// Shared LSU definitions: state encoding seen by the core scheduler and
// the core pipeline states the LSU reacts to.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_IDLE       = 3'd0,
    LSU_REQUESTING = 3'd1,
    LSU_WAITING    = 3'd2,
    LSU_DONE       = 3'd3,
    LSU_ERROR      = 3'd4
  } lsu_state_t;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  // A disabled timeout (0) still needs a one-bit counter to stay legal.
  function automatic int ctr_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Saturating WAITING-cycle counter; flags expiry on the last allowed cycle
// so the owner can leave WAITING on that same edge.
module lsu_timeout_ctr
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic clear_i,
  input  logic incr_i,
  output logic expired_o
);

  localparam int W = ctr_width(TIMEOUT);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] count_q;

  // count cycles, holding when the thread is disabled and never wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (enable_i) begin
      if (clear_i) begin
        count_q <= '0;
      end else if (incr_i && (count_q != {W{1'b1}})) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign expired_o = (TIMEOUT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/lsu_timed.sv
// Per-thread load/store unit with a bounded wait for the memory response;
// a response that never arrives parks the unit in ERROR until UPDATE.
module lsu_timed
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        core_state,
  input  logic              mem_read_en,
  input  logic              mem_write_en,
  input  logic [ADDR_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic              mem_read_valid,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic              mem_read_ready,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              mem_write_valid,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic              mem_write_ready,
  output logic [2:0]        lsu_state,
  output logic [DATA_W-1:0] lsu_out,
  output logic              lsu_error
);

  lsu_state_t        state_q;
  logic              is_write_q;
  logic              read_valid_q;
  logic              write_valid_q;
  logic [ADDR_W-1:0] read_addr_q;
  logic [ADDR_W-1:0] write_addr_q;
  logic [DATA_W-1:0] write_data_q;
  logic [DATA_W-1:0] out_q;
  logic              error_q;

  logic ack_s;
  logic expired_s;

  // only the channel of the latched operation may complete it
  assign ack_s = is_write_q ? mem_write_ready : mem_read_ready;

  lsu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .enable_i (enable),
    .clear_i  (state_q == LSU_REQUESTING),
    .incr_i   ((state_q == LSU_WAITING) && !ack_s),
    .expired_o(expired_s)
  );

  // operation sequencing with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LSU_IDLE;
      is_write_q    <= 1'b0;
      read_valid_q  <= 1'b0;
      write_valid_q <= 1'b0;
      read_addr_q   <= '0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      out_q         <= '0;
      error_q       <= 1'b0;
    end else if (enable) begin
      case (state_q)
        LSU_IDLE: begin
          if (core_state == CORE_REQUEST) begin
            if (mem_read_en && mem_write_en) begin
              state_q <= LSU_ERROR;
              error_q <= 1'b1;
            end else if (mem_read_en || mem_write_en) begin
              is_write_q <= mem_write_en;
              state_q    <= LSU_REQUESTING;
            end
          end
        end
        LSU_REQUESTING: begin
          if (is_write_q) begin
            write_valid_q <= 1'b1;
            write_addr_q  <= rs;
            write_data_q  <= rt;
          end else begin
            read_valid_q <= 1'b1;
            read_addr_q  <= rs;
          end
          state_q <= LSU_WAITING;
        end
        LSU_WAITING: begin
          // a response on the expiry cycle still counts as a completion
          if (ack_s) begin
            if (!is_write_q) begin
              out_q <= mem_read_data;
            end
            read_valid_q  <= 1'b0;
            write_valid_q <= 1'b0;
            state_q       <= LSU_DONE;
          end else if (expired_s) begin
            read_valid_q  <= 1'b0;
            write_valid_q <= 1'b0;
            state_q       <= LSU_ERROR;
            error_q       <= 1'b1;
          end
        end
        LSU_DONE, LSU_ERROR: begin
          if (core_state == CORE_UPDATE) begin
            state_q <= LSU_IDLE;
            error_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= LSU_IDLE;
          read_valid_q  <= 1'b0;
          write_valid_q <= 1'b0;
          error_q       <= 1'b0;
        end
      endcase
    end
  end

  assign lsu_state         = state_q;
  assign lsu_out           = out_q;
  assign lsu_error         = error_q;
  assign mem_read_valid    = read_valid_q;
  assign mem_read_address  = read_addr_q;
  assign mem_write_valid   = write_valid_q;
  assign mem_write_address = write_addr_q;
  assign mem_write_data    = write_data_q;

endmodule

// File: doc/lsu_timed.md
LSU_TIMED -- requirements
Module: lsu_timed

Interface
REQ-001 Parameter DATA_W, default 8, width of data path.
REQ-002 Parameter ADDR_W, default 8, width of memory address.
REQ-003 Parameter TIMEOUT, default 16, max WAITING cycles before error; 0 disables timeout.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  thread active; when low all registers hold.
REQ-007 core_state  in  3  core pipeline state (REQUEST=3'b011, UPDATE=3'b110).
REQ-008 mem_read_en  in  1  decoded LDR.
REQ-009 mem_write_en  in  1  decoded STR.
REQ-010 rs  in  ADDR_W  memory address operand.
REQ-011 rt  in  DATA_W  store data operand.
REQ-012 mem_read_valid  out  1  read request.
REQ-013 mem_read_address  out  ADDR_W  read address.
REQ-014 mem_read_ready  in  1  read response strobe.
REQ-015 mem_read_data  in  DATA_W  read response data.
REQ-016 mem_write_valid  out  1  write request.
REQ-017 mem_write_address  out  ADDR_W  write address.
REQ-018 mem_write_data  out  DATA_W  write data.
REQ-019 mem_write_ready  in  1  write acknowledge.
REQ-020 lsu_state  out  3  IDLE=0, REQUESTING=1, WAITING=2, DONE=3, ERROR=4.
REQ-021 lsu_out  out  DATA_W  last loaded data.
REQ-022 lsu_error  out  1  high only while in ERROR.

Function
REQ-023 IDLE -> REQUESTING when enable, core_state==REQUEST and exactly one of mem_read_en/mem_write_en high; operation type latched.
REQ-024 IDLE with core_state==REQUEST and both enables high -> ERROR directly; no memory request issued.
REQ-025 REQUESTING: assert latched-type valid, drive address=rs (write: data=rt), clear timeout counter, -> WAITING; one cycle.
REQ-026 WAITING read: on mem_read_ready, capture mem_read_data into lsu_out, deassert mem_read_valid, -> DONE same edge.
REQ-027 WAITING write: on mem_write_ready, deassert mem_write_valid, -> DONE; lsu_out unchanged.
REQ-028 Ready of the non-active channel is ignored in all states.
REQ-029 WAITING without ready: counter increments; when TIMEOUT!=0 and counter reaches TIMEOUT-1 without ready, deassert valid, -> ERROR; lsu_out unchanged.
REQ-030 Ready arriving on the same cycle the timeout fires wins: complete normally -> DONE.
REQ-031 DONE and ERROR -> IDLE when core_state==UPDATE; otherwise hold.
REQ-032 Minimum request-to-DONE latency: 3 edges after entering REQUEST (IDLE->REQ->WAIT->DONE with ready in first WAITING cycle).
REQ-033 Address/data outputs hold last driven values when valid is low.
REQ-034 Counter width $clog2(TIMEOUT+1), saturating; no wrap.
REQ-035 enable low mid-operation freezes state, counter and valid levels; resumes on enable high.

Reset
REQ-036 reset has priority over enable: lsu_state=IDLE, lsu_out=0, lsu_error=0, both valids=0, addresses=0, write data=0, counter=0.
REQ-037 reset during WAITING drops valid on the next edge; no completion recorded.

Structure
REQ-038 Package lsu_pkg holds the lsu_state_t enum and core-state constants CORE_REQUEST, CORE_UPDATE, shared with the core scheduler.
REQ-039 One sub-module lsu_timeout_ctr (clear, increment, expired flag, parameter TIMEOUT) is natural; the rest is flat.

Verification
REQ-040 LDR rs=0x21, mem returns 0x5A with ready 2 cycles after valid -> lsu_out=0x5A, state DONE, then IDLE on UPDATE.
REQ-041 STR rs=0x10 rt=0xC3, ready in first WAITING cycle -> write_valid high exactly 1 cycle, address 0x10, data 0xC3, DONE.
REQ-042 TIMEOUT=4, LDR never acknowledged -> ERROR after 4 WAITING cycles, lsu_error=1, read_valid=0, lsu_out unchanged.
REQ-043 Both enables high at REQUEST -> ERROR next edge, neither valid ever asserted.
REQ-044 reset asserted in WAITING -> all outputs reset values next edge; enable low for 5 cycles mid-WAITING -> state and valid held.
REQ-045 DATA_W=32, ADDR_W=16: LDR rs=0xBEEF returns 0xDEADBEEF -> lsu_out=0xDEADBEEF.
